// File: rtl/pif_led_pwm.sv
`default_nettype none
// ============================================================================
// Module  : pif_led_pwm
// Brief   : Multi-channel active-low LED driver: tick prescaler, shared
//           breathing ramp and per-channel first-order sigma-delta
//           (off / solid / breathe / blink). Optional macro PIF_LED_PHASE_EN
//           spreads the channels evenly in ramp phase.
// Revision: 1.0 - initial release
// ============================================================================
module pif_led_pwm #(
    parameter  int CHANNELS = 2,
    parameter  int BITS     = 5,
    parameter  int TICK_DIV = 177333,
    localparam int CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                Clk,
    input  logic                RstN,
    input  logic                cfg_we,
    input  logic [CHW-1:0]      cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [BITS-1:0]     cfg_level,
    output logic [CHANNELS-1:0] led_n,
    output logic                tick
);

    localparam int              c_PW     = $clog2(TICK_DIV);
    localparam logic [c_PW-1:0] c_RELOAD = c_PW'(TICK_DIV - 1);

    localparam logic [1:0] c_MODE_OFF     = 2'b00;
    localparam logic [1:0] c_MODE_SOLID   = 2'b01;
    localparam logic [1:0] c_MODE_BREATHE = 2'b10;
    localparam logic [1:0] c_MODE_BLINK   = 2'b11;

    logic [c_PW-1:0] r_presc;
    logic            r_tick;
    logic [BITS:0]   r_ramp;
    logic            w_wr_ok;

    // Tick is registered, so it is visible the cycle after the count hits 0.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            r_presc <= c_RELOAD;
            r_tick  <= 1'b0;
        end else begin
            r_tick  <= (r_presc == '0);
            r_presc <= (r_presc == '0) ? c_RELOAD : r_presc - 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            r_ramp <= '0;
        end else if (r_tick) begin
            r_ramp <= r_ramp + 1'b1;
        end
    end

    assign tick    = r_tick;
    assign w_wr_ok = cfg_we && (32'(cfg_ch) < CHANNELS);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [BITS:0]   w_rc;
        logic [BITS-1:0] w_tri;
        logic [BITS:0]   w_sum;
        logic [1:0]      r_mode;
        logic [BITS-1:0] r_level;
        logic [BITS-1:0] r_duty;
        logic [BITS-1:0] r_acc;
        logic            r_led;

`ifdef PIF_LED_PHASE_EN
        localparam logic [BITS:0] c_OFFSET =
            (BITS+1)'(c * ((1 << (BITS + 1)) / CHANNELS));
        assign w_rc = r_ramp + c_OFFSET;
`else
        assign w_rc = r_ramp;
`endif

        assign w_tri = w_rc[BITS] ? ~w_rc[BITS-1:0] : w_rc[BITS-1:0];
        assign w_sum = {1'b0, r_acc} + {1'b0, r_duty};

        // The accumulator free-runs; mode changes never clear it.
        always_ff @(posedge Clk or negedge RstN) begin
            if (!RstN) begin
                r_mode  <= c_MODE_OFF;
                r_level <= '0;
                r_duty  <= '0;
                r_acc   <= '0;
                r_led   <= 1'b1;
            end else begin
                if (w_wr_ok && (cfg_ch == CHW'(c))) begin
                    r_mode  <= cfg_mode;
                    r_level <= cfg_level;
                end

                case (r_mode)
                    c_MODE_SOLID:   r_duty <= r_level;
                    c_MODE_BREATHE: r_duty <= w_tri;
                    default:        r_duty <= '0;
                endcase

                r_acc <= w_sum[BITS-1:0];

                case (r_mode)
                    c_MODE_OFF:   r_led <= 1'b1;
                    c_MODE_BLINK: r_led <= w_rc[BITS];
                    default:      r_led <= ~w_sum[BITS];
                endcase
            end
        end

        assign led_n[c] = r_led;
    end

endmodule
`default_nettype wire

// File: tb/tb_pif_led_pwm.sv
`default_nettype none
// ============================================================================
// Module  : tb_pif_led_pwm
// Brief   : Scoreboard bench for pif_led_pwm (a 2-channel TICK_DIV=8 instance
//           and a 3-channel TICK_DIV=32 instance for breathe timing).
// Revision: 1.0 - initial release
// ============================================================================
module tb_pif_led_pwm;

    localparam int BITS   = 5;
    localparam int CH_A   = 2;
    localparam int DIV_A  = 8;
    localparam int CH_B   = 3;
    localparam int DIV_B  = 32;
    localparam int RAMP_N = 1 << (BITS + 1);

    logic            Clk = 1'b0;
    logic            RstN;

    logic            a_we;
    logic [0:0]      a_ch;
    logic [1:0]      a_mode;
    logic [BITS-1:0] a_level;
    logic [1:0]      a_led;
    logic            a_tick;

    logic            b_we;
    logic [1:0]      b_ch;
    logic [1:0]      b_mode;
    logic [BITS-1:0] b_level;
    logic [2:0]      b_led;
    logic            b_tick;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;
    int sb[$];

    pif_led_pwm #(.CHANNELS(CH_A), .BITS(BITS), .TICK_DIV(DIV_A)) u_dut_a (
        .Clk(Clk), .RstN(RstN), .cfg_we(a_we), .cfg_ch(a_ch), .cfg_mode(a_mode),
        .cfg_level(a_level), .led_n(a_led), .tick(a_tick)
    );

    pif_led_pwm #(.CHANNELS(CH_B), .BITS(BITS), .TICK_DIV(DIV_B)) u_dut_b (
        .Clk(Clk), .RstN(RstN), .cfg_we(b_we), .cfg_ch(b_ch), .cfg_mode(b_mode),
        .cfg_level(b_level), .led_n(b_led), .tick(b_tick)
    );

    always #5 Clk = ~Clk;

    // Rising edges since reset release; the reference timeline for the model.
    always @(posedge Clk or negedge RstN) begin
        if (!RstN) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic int ramp_at(input int e, input int div);
        if (e < 1) return 0;
        return ((e - 1) / div) % RAMP_N;
    endfunction

    function automatic int tri_of(input int r);
        int m;
        m = r % RAMP_N;
        return (m < RAMP_N / 2) ? m : (RAMP_N - 1 - m);
    endfunction

    function automatic int phase_of(input int c, input int chans);
`ifdef PIF_LED_PHASE_EN
        return c * (RAMP_N / chans);
`else
        return (c * 0) + (chans * 0);
`endif
    endfunction

    task automatic write_a(input int ch, input int mode, input int level);
        @(negedge Clk);
        a_we = 1'b1; a_ch = 1'(ch); a_mode = 2'(mode); a_level = BITS'(level);
        @(posedge Clk); #1;
        a_we = 1'b0;
    endtask

    task automatic write_b(input int ch, input int mode, input int level);
        @(negedge Clk);
        b_we = 1'b1; b_ch = 2'(ch); b_mode = 2'(mode); b_level = BITS'(level);
        @(posedge Clk); #1;
        b_we = 1'b0;
    endtask

    task automatic check_tick_run(input string tag, input int edges);
        int want_a, want_b;
        for (int e = 1; e <= edges; e++) begin
            sb.push_back((e % DIV_A == 0) ? 1 : 0);
            sb.push_back((e % DIV_B == 0) ? 1 : 0);
            @(posedge Clk); #1;
            want_a = sb.pop_front();
            want_b = sb.pop_front();
            n_checks++;
            if (a_tick !== 1'(want_a)) begin
                n_fail++;
                $display("FAIL %s tick_a edge %0d: got %b expected %0d", tag, e, a_tick, want_a);
            end
            n_checks++;
            if (b_tick !== 1'(want_b)) begin
                n_fail++;
                $display("FAIL %s tick_b edge %0d: got %b expected %0d", tag, e, b_tick, want_b);
            end
        end
    endtask

    task automatic test_reset;
        RstN = 1'b0;
        a_we = 1'b0; a_ch = '0; a_mode = '0; a_level = '0;
        b_we = 1'b0; b_ch = '0; b_mode = '0; b_level = '0;
        repeat (3) @(negedge Clk);
        n_checks++;
        if (a_led !== 2'b11 || b_led !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_led: got %b/%b expected 11/111", a_led, b_led);
        end
        n_checks++;
        if (a_tick !== 1'b0 || b_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tick: got %b/%b expected 0/0", a_tick, b_tick);
        end
        RstN = 1'b1;
        check_tick_run("release", 40);
    endtask

    task automatic test_solid;
        int cnt, last, gap_bad, ch1_bad, want;
        write_a(0, 1, 8);
        @(posedge Clk); #1;
        for (int w = 0; w < 3; w++) begin
            sb.push_back(8);
            cnt = 0; last = -1; gap_bad = 0; ch1_bad = 0;
            for (int k = 0; k < 32; k++) begin
                @(posedge Clk); #1;
                if (a_led[0] === 1'b0) begin
                    if (last >= 0 && (k - last) != 4) gap_bad++;
                    last = k;
                    cnt++;
                end
                if (a_led[1] !== 1'b1) ch1_bad++;
            end
            want = sb.pop_front();
            n_checks++;
            if (cnt != want) begin
                n_fail++;
                $display("FAIL solid_count win %0d: got %0d expected %0d", w, cnt, want);
            end
            n_checks++;
            if (gap_bad != 0) begin
                n_fail++;
                $display("FAIL solid_spacing win %0d: got %0d bad gaps expected 0", w, gap_bad);
            end
            n_checks++;
            if (ch1_bad != 0) begin
                n_fail++;
                $display("FAIL solid_ch1_idle win %0d: got %0d low cycles expected 0", w, ch1_bad);
            end
        end
    endtask

    task automatic test_blink;
        int e, want;
`ifdef PIF_LED_PHASE_EN
        write_a(0, 3, 0);
`endif
        write_a(1, 3, 0);
        for (int k = 0; k < 520; k++) begin
            @(posedge Clk); #1;
            e = cyc;
            sb.push_back(((ramp_at(e - 1, DIV_A) + phase_of(1, CH_A)) % RAMP_N) >> BITS);
`ifdef PIF_LED_PHASE_EN
            sb.push_back(((ramp_at(e - 1, DIV_A) + phase_of(0, CH_A)) % RAMP_N) >> BITS);
`endif
            want = sb.pop_front();
            n_checks++;
            if (a_led[1] !== 1'(want)) begin
                n_fail++;
                $display("FAIL blink_ch1 edge %0d: got %b expected %0d", e, a_led[1], want);
            end
`ifdef PIF_LED_PHASE_EN
            want = sb.pop_front();
            n_checks++;
            if (a_led[0] !== 1'(want)) begin
                n_fail++;
                $display("FAIL blink_ch0 edge %0d: got %b expected %0d", e, a_led[0], want);
            end
`endif
        end
    endtask

    task automatic test_ignored_write;
        int bad;
        write_b(3, 1, 20);
        bad = 0;
        repeat (40) begin
            @(posedge Clk); #1;
            if (b_led !== 3'b111) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL ignored_write: got %0d lit cycles expected 0", bad);
        end
    endtask

    task automatic count_window(input int ch, input string tag, input int idx);
        int cnt, want;
        cnt = 0;
        repeat (32) begin
            @(posedge Clk); #1;
            if (b_led[ch] === 1'b0) cnt++;
        end
        want = sb.pop_front();
        n_checks++;
        if (cnt != want) begin
            n_fail++;
            $display("FAIL %s win %0d: got %0d low cycles expected %0d", tag, idx, cnt, want);
        end
    endtask

    task automatic test_breathe;
        int found, r0;
        write_b(0, 2, 0);
        found = 0;
        for (int i = 0; i < 64 && found == 0; i++) begin
            @(posedge Clk); #1;
            if ((cyc - 1) % DIV_B == 0) found = 1;
        end
        n_checks++;
        if (found == 0) begin
            n_fail++;
            $display("FAIL breathe_align: got no ramp edge expected one within 64 cycles");
        end else begin
            r0 = ramp_at(cyc, DIV_B);
            @(posedge Clk); #1;
            for (int w = 0; w < 66; w++) begin
                sb.push_back(tri_of(r0 + w + phase_of(0, CH_B)));
                count_window(0, "breathe", w);
            end
        end
    endtask

    task automatic test_switch_off;
        int bad;
        write_b(0, 0, 0);
        @(posedge Clk); #1;
        bad = 0;
        repeat (64) begin
            @(posedge Clk); #1;
            if (b_led[0] !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL switch_off: got %0d lit cycles expected 0", bad);
        end
    endtask

    task automatic test_write_on_tick;
        int found, r;
        found = 0;
        for (int i = 0; i < 80 && found == 0; i++) begin
            @(negedge Clk);
            if (cyc > 0 && cyc % DIV_B == 0) found = 1;
        end
        n_checks++;
        if (found == 0 || b_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL tick_write_align: got tick %b expected 1", b_tick);
        end else begin
            b_we = 1'b1; b_ch = 2'd1; b_mode = 2'b10; b_level = '0;
            @(posedge Clk); #1;
            b_we = 1'b0;
            r = ramp_at(cyc, DIV_B);
            @(posedge Clk); #1;
            for (int w = 0; w < 2; w++) begin
                sb.push_back(tri_of(r + w + phase_of(1, CH_B)));
                count_window(1, "tick_write", w);
            end
        end
    endtask

    task automatic test_async_reset;
        int found;
        found = 0;
        for (int i = 0; i < 600 && found == 0; i++) begin
            @(negedge Clk);
            if (a_led[1] === 1'b0) found = 1;
        end
        n_checks++;
        if (found == 0) begin
            n_fail++;
            $display("FAIL async_pre: got led_n %b expected ch1 lit within 600 cycles", a_led);
        end
        #2;
        RstN = 1'b0;
        #1;
        n_checks++;
        if (a_led !== 2'b11 || b_led !== 3'b111) begin
            n_fail++;
            $display("FAIL async_led: got %b/%b expected 11/111", a_led, b_led);
        end
        n_checks++;
        if (a_tick !== 1'b0 || b_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL async_tick: got %b/%b expected 0/0", a_tick, b_tick);
        end
        @(negedge Clk);
        RstN = 1'b1;
        check_tick_run("restart", 16);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_solid();
        test_blink();
        test_ignored_write();
        test_breathe();
        test_switch_off();
        test_write_on_tick();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pif_led_pwm.md
# pif_led_pwm

Parametrised multi-channel LED driver for the PIF board's status LEDs. It generates a tick from the on-chip oscillator clock and runs a shared breathing ramp from that tick. Each channel drives an active-low LED through a first-order sigma-delta modulator, in one of four modes: off, solid level, breathe or blink. A single-cycle configuration write port lets control logic set each channel's mode and level at run time.

## Interface
Parameters:
- `CHANNELS`, 2: number of LED channels (1..16).
- `BITS`, 5: brightness resolution; the ramp is `BITS+1` bits wide.
- `TICK_DIV`, 177333: oscillator cycles per tick (26.6 MHz / 150 Hz); minimum 2.
- `CHW`, derived: `max(1, clog2(CHANNELS))`.

Ports:
- `Clk` input 1: oscillator clock; all logic runs on its rising edge.
- `RstN` input 1: asynchronous, active-low reset.
- `cfg_we` input 1: configuration write strobe, one cycle per write.
- `cfg_ch` input `CHW`: target channel; writes with `cfg_ch >= CHANNELS` are ignored.
- `cfg_mode` input 2: 00 off, 01 solid, 10 breathe, 11 blink.
- `cfg_level` input `BITS`: duty for solid mode, as a count out of 2^`BITS`.
- `led_n` output `CHANNELS`: active-low LED drives, registered.
- `tick` output 1: one-cycle pulse, once per tick period.

## Operation
- **Prescaler:** a down-counter loads `TICK_DIV-1`, decrements each cycle and asserts `tick` for one cycle when it reaches 0, reloading in that same cycle.
- **Ramp `R`:** `BITS+1` bits, increments on `tick` and wraps from 2^(`BITS+1`)-1 to 0.
- **Per-channel ramp `Rc`:** equals `R`, or `R` plus a phase offset when `PIF_LED_PHASE_EN` is defined.
- **Triangle:** `T = Rc[BITS] ? ~Rc[BITS-1:0] : Rc[BITS-1:0]`.
- **Per-channel state:** mode register (2 bits), level register (`BITS`), duty register (`BITS`) and accumulator (`BITS`).
- **Duty selection, registered each cycle:**
  - off: 0.
  - solid: level.
  - breathe: `T`.
  - blink: not used.
- **Sigma-delta:** `{carry, acc} <= acc + duty` each cycle. The accumulator free-runs and is never cleared by `tick` or by a mode change.
- **Output register:**
  - off: `led_n = 1`.
  - blink: `led_n = Rc[BITS]` (on for the first half of the ramp, fully on, no modulation).
  - solid or breathe: `led_n = ~carry`.
- With constant duty D, any 2^`BITS` consecutive carries contain exactly D ones. Full-scale duty is therefore (2^`BITS`-1)/2^`BITS`; solid mode never reaches 100%.
- A write of a mode and level updates only the addressed channel. Other channels are undisturbed.

## Timing
- **Reset values:**
  - `led_n` all ones, `tick` 0.
  - Prescaler `TICK_DIV-1`, `R` 0.
  - Modes off, levels, duties and accumulators 0.
  - Reset takes effect immediately, without a clock edge.
- **First tick:** `tick` first asserts on the cycle after `TICK_DIV` rising edges following `RstN` deassertion, then every `TICK_DIV` cycles.
- **Ramp update:** `R` takes its new value on the edge where `tick` is high; `T` follows combinationally.
- **Config to LED latency:**
  - Write sampled at edge N, mode/level registered.
  - Duty updates at edge N+1.
  - The accumulator carry and `led_n` (registered together) reflect the new duty from edge N+2.
  - A blink/off mode change reaches `led_n` at edge N+1.
- **Ramp to LED latency:** a ramp change reaches `led_n` two edges after `tick`.
- **Write coinciding with `tick`:** both take effect independently; the new mode sees the already-incremented `R`.
- **Back-to-back writes** to the same channel: the last one wins, each with its own latency.
- **Reset mid-operation:** all state returns to reset values asynchronously. The prescaler restarts its full `TICK_DIV` count.

## Configuration
- **`PIF_LED_PHASE_EN` defined:**
  - `Rc = (R + c*(2^(BITS+1)/CHANNELS)) mod 2^(BITS+1)` for channel c, using integer division.
  - Breathe and blink channels are spread evenly in phase.
- **Not defined:** all channels use `Rc = R` and are in phase. No other behaviour differs.

## Test plan
Bench defaults: `CHANNELS=2`, `BITS=5`, `TICK_DIV=8`.

1. **Reset and tick.** Release `RstN`. Require `led_n=2'b11` and `tick=0`, the first `tick` on cycle 8, then one every 8 cycles. Assert `RstN` low mid-count; `led_n` must return to 11 with no clock edge.
2. **Solid level.** Write ch0 solid with level 8. From edge N+2, every 32-cycle window has exactly 8 cycles of `led_n[0]=0`, one every 4 cycles. `led_n[1]` stays 1.
3. **Blink.** Write ch1 blink. `led_n[1]=0` for 32 ticks (256 cycles), then 1 for 256 cycles, repeating. With `PIF_LED_PHASE_EN` and ch0 also in blink, ch0 and ch1 are exactly complementary.
4. **Breathe.** Run with `TICK_DIV=32` and write ch0 breathe. In each 32-cycle window aligned two edges after `tick`, the low-cycle count equals `T`: 0, 1, …, 31 across rising ticks, then 31, …, 0, repeating every 64 ticks.
5. **Ignored write and switch-off.** Write `cfg_ch=3` with solid mode; no channel changes. Write ch0 off while it is breathing; `led_n[0]=1` from edge N+2 and thereafter.
6. **Write on a tick.** Issue a ch1 breathe write in the same cycle as `tick`. `R` increments normally, and ch1's first duty equals `T` of the new `R`.
